// File: rtl/ila_pkg.sv
// Shared types and defaults for the integrated logic-analyzer capture core.
package ila_pkg;

  localparam int unsigned ILA_TRIG_WIDTH = 52;
  localparam int unsigned ILA_ADDR_W     = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } ila_state_e;

  // States in which the sample buffer is being written.
  function automatic logic is_capturing(input ila_state_e s);
    return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/ila_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module ila_sample_ram
  import ila_pkg::*;
#(
  parameter int unsigned WIDTH  = ILA_TRIG_WIDTH,
  parameter int unsigned ADDR_W = ILA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ila_capture.sv
// Logic-analyzer capture core: circular sample buffer with masked-equality
// trigger, programmable pre-trigger depth and post-trigger fill.
module ila_capture
  import ila_pkg::*;
#(
  parameter int unsigned TRIG_WIDTH = ILA_TRIG_WIDTH,
  parameter int unsigned ADDR_W     = ILA_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [TRIG_WIDTH-1:0] trig0_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [TRIG_WIDTH-1:0] trig_value_i,
  input  logic [TRIG_WIDTH-1:0] trig_mask_i,
  input  logic [ADDR_W-1:0]     pre_trig_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [TRIG_WIDTH-1:0] rd_data_o,
  output logic                  busy_o,
  output logic                  triggered_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     trig_ptr_o,
  output logic [ADDR_W-1:0]     start_ptr_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  ila_state_e            state_q, state_d;
  logic [TRIG_WIDTH-1:0] sample_q;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     trig_ptr_q, trig_ptr_d;
  logic [ADDR_W-1:0]     start_ptr_q, start_ptr_d;
  logic                  triggered_q, triggered_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_c;
  logic                  match_c;
  logic                  prefill_last_c;
  logic [CNT_W-1:0]      post_len_c;

  assign match_c        = ((sample_q ^ trig_value_i) & trig_mask_i) == '0;
  assign prefill_last_c = (cnt_q + CNT_W'(1)) == CNT_W'(pre_trig_i);
  assign post_len_c     = CNT_W'(DEPTH - 1) - CNT_W'(pre_trig_i);

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks arm, arm restarts from any state.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else if (arm_i) begin
      state_d = (pre_trig_i == '0) ? ST_WAIT_TRIG : ST_PREFILL;
    end else begin
      unique case (state_q)
        ST_PREFILL: begin
          if (prefill_last_c) state_d = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          if (match_c) state_d = (post_len_c == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: begin
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Output / datapath logic: write enable, pointers, counter, trigger capture.
  always_comb begin
    wr_en_c     = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    trig_ptr_d  = trig_ptr_q;
    start_ptr_d = start_ptr_q;
    triggered_d = triggered_q;
    busy_d      = is_capturing(state_q);
    done_d      = (state_q == ST_DONE);
    if (abort_i) begin
      wr_en_c = 1'b0;
    end else if (arm_i) begin
      wr_ptr_d    = '0;
      cnt_d       = '0;
      triggered_d = 1'b0;
    end else if (is_capturing(state_q)) begin
      wr_en_c  = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      unique case (state_q)
        ST_PREFILL: cnt_d = cnt_q + CNT_W'(1);
        ST_WAIT_TRIG: begin
          if (match_c) begin
            trig_ptr_d  = wr_ptr_q;
            start_ptr_d = wr_ptr_q - pre_trig_i;
            triggered_d = 1'b1;
            cnt_d       = post_len_c;
          end
        end
        ST_POST: cnt_d = cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sample_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_ptr_q  <= '0;
      start_ptr_q <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sample_q    <= trig0_i;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      trig_ptr_q  <= trig_ptr_d;
      start_ptr_q <= start_ptr_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ila_sample_ram #(
    .WIDTH  (TRIG_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_b     (rst_b),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (sample_q),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o)
  );

  assign busy_o      = busy_q;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign trig_ptr_o  = trig_ptr_q;
  assign start_ptr_o = start_ptr_q;

endmodule

// File: tb/tb_ila_capture.sv
// Scoreboard bench for ila_capture (DEPTH 16): samples fed after each arm are
// logged and the expected buffer image is derived from that log.
module tb_ila_capture;

  localparam int unsigned TW     = 52;
  localparam int unsigned AW     = 4;
  localparam int          DEPTH  = 16;
  localparam int          BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [TW-1:0] trig0 = '0;
  logic [TW-1:0] trig_value = '0;
  logic [TW-1:0] trig_mask = '0;
  logic [TW-1:0] rd_data;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] pre_trig = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] trig_ptr;
  logic [AW-1:0] start_ptr;
  logic          busy;
  logic          triggered;
  logic          done;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [TW-1:0] seen [$];
  logic [TW-1:0] exp_q [$];
  bit            log_en = 1'b0;
  bit            use_cnt = 1'b0;
  bit            rd_req = 1'b0;
  bit            rd_vld = 1'b0;

  always #5 clk = ~clk;

  ila_capture #(.TRIG_WIDTH(TW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .trig0_i      (trig0),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_value_i (trig_value),
    .trig_mask_i  (trig_mask),
    .pre_trig_i   (pre_trig),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .busy_o       (busy),
    .triggered_o  (triggered),
    .done_o       (done),
    .trig_ptr_o   (trig_ptr),
    .start_ptr_o  (start_ptr)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Log of probe values seen at each sampling edge since the last arm.
  always @(posedge clk) if (log_en) seen.push_back(trig0);

  always @(posedge clk) rd_vld <= rd_req;

  // Readout monitor: pops the scoreboard whenever read data is due.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got 0x%0h, required no pending read", rd_data);
      end else begin
        check("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    arm   = 1'b0;
    abort = 1'b0;
    if (use_cnt) trig0 = trig0 + TW'(1);
    else         trig0 = TW'({$urandom(), $urandom()});
  endtask

  task automatic do_arm(input int p, input logic [TW-1:0] val, input logic [TW-1:0] msk,
                        input bit cnt_mode, input logic [TW-1:0] start, input bit exp_busy);
    pre_trig   = AW'(p);
    trig_value = val;
    trig_mask  = msk;
    use_cnt    = cnt_mode;
    if (cnt_mode) trig0 = start;
    seen.delete();
    log_en = 1'b1;
    arm    = 1'b1;
    tick();
    @(negedge clk);
    check("busy_at_arm_edge", 64'(busy), 64'(exp_busy));
    check("triggered_cleared", 64'(triggered), 64'(0));
    tick();
    @(negedge clk);
    check("busy_after_arm", 64'(busy), 64'(1));
  endtask

  task automatic finish_capture(input int p);
    int j;
    int k;
    int st;
    j = 1;
    while (!done && j < BUDGET) begin
      tick();
      @(negedge clk);
      j++;
    end
    check("done_seen", 64'(done), 64'(1));
    log_en = 1'b0;
    if (!done) return;
    k = -1;
    for (int i = p; i < seen.size(); i++) begin
      if (((seen[i] ^ trig_value) & trig_mask) == '0) begin
        k = i;
        break;
      end
    end
    if (k < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL model_trigger: got done after %0d cycles, required a match in %0d logged samples",
               j, seen.size());
      return;
    end
    st = (k - p) % DEPTH;
    check("done_latency", 64'(j), 64'(k + DEPTH - p + 1));
    check("triggered", 64'(triggered), 64'(1));
    check("trig_ptr", 64'(trig_ptr), 64'(k % DEPTH));
    check("start_ptr", 64'(start_ptr), 64'(st));
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(st + i);
      exp_q.push_back(seen[k - p + i]);
      rd_req = 1'b1;
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rd_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [TW-1:0] msk;
    int            p;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_triggered", 64'(triggered), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_trig_ptr", 64'(trig_ptr), 64'(0));
    check("rst_start_ptr", 64'(start_ptr), 64'(0));
    check("rst_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk);
    #1 rst_b = 1'b1;

    // Exact-value trigger with pre-trigger history.
    do_arm(4, TW'(20), '1, 1'b1, TW'(0), 1'b0);
    finish_capture(4);

    // Zero mask: trigger on first sample.
    do_arm(0, TW'(0), '0, 1'b1, TW'(100), 1'b0);
    finish_capture(0);

    // Maximum pre-trigger: PREFILL match ignored, DONE straight after trigger.
    do_arm(15, TW'(3), TW'(15), 1'b1, TW'(0), 1'b0);
    finish_capture(15);

    // Masked low-nibble compare.
    do_arm(7, TW'(5), TW'(15), 1'b1, TW'($urandom_range(0, 100)), 1'b0);
    finish_capture(7);

    // arm and abort together mid-POST: abort wins, triggered retained.
    do_arm(2, TW'(0), '0, 1'b1, TW'(0), 1'b0);
    repeat (4) tick();
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    log_en = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_triggered", 64'(triggered), 64'(1));

    // Re-arm during POST restarts the capture.
    do_arm(2, TW'(0), '0, 1'b1, TW'(0), 1'b0);
    repeat (4) tick();
    check("post_triggered", 64'(triggered), 64'(1));
    do_arm(3, TW'(9), TW'(15), 1'b1, TW'(0), 1'b1);
    finish_capture(3);

    // Random probe data, random pre-trigger depth, sparse random mask.
    for (int it = 0; it < 8; it++) begin
      msk = '0;
      for (int b = 0; b < 3; b++) msk[$urandom_range(0, TW - 1)] = 1'b1;
      p = $urandom_range(0, DEPTH - 1);
      do_arm(p, TW'({$urandom(), $urandom()}), msk, 1'b0, TW'(0), 1'b0);
      finish_capture(p);
    end

    // Asynchronous reset in the middle of POST.
    do_arm(1, TW'(0), '0, 1'b1, TW'(0), 1'b0);
    repeat (4) tick();
    log_en = 1'b0;
    rst_b  = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_triggered", 64'(triggered), 64'(0));
    check("midrst_trig_ptr", 64'(trig_ptr), 64'(0));
    @(posedge clk);
    #1 rst_b = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
